// File: rtl/fwnoc_ni_tx_if.sv
// Handshake bundle between a traffic source and the fwnoc NI transmit stage:
// command channel, payload channel and the flit output toward the NoC ingress port.
interface fwnoc_ni_tx_if;
  logic [7:0]  cmd_dst_x;
  logic [7:0]  cmd_dst_y;
  logic [7:0]  cmd_len;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] pl_dat;
  logic        pl_valid;
  logic        pl_ready;
  logic [31:0] o_dat;
  logic        o_valid;
  logic        o_ready;

  modport master (
    output cmd_dst_x, cmd_dst_y, cmd_len, cmd_valid, pl_dat, pl_valid, o_ready,
    input  cmd_ready, pl_ready, o_dat, o_valid
  );

  modport slave (
    input  cmd_dst_x, cmd_dst_y, cmd_len, cmd_valid, pl_dat, pl_valid, o_ready,
    output cmd_ready, pl_ready, o_dat, o_valid
  );
endinterface

// File: rtl/fwnoc_ni_tx.sv
// NoC network-interface transmit stage: turns a command plus payload words into
// a header flit followed by len payload flits behind one output register.
module fwnoc_ni_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int SRC_X      = 0,
  parameter int SRC_Y      = 0
) (
  input  logic                clock,
  input  logic                reset,
  fwnoc_ni_tx_if.slave        bus,
  output logic [15:0]         pkt_count
);
  typedef enum logic [0:0] {IDLE = 1'b0, PAYLOAD = 1'b1} state_e;

  localparam logic [3:0] SRC_X_4 = 4'(SRC_X);
  localparam logic [3:0] SRC_Y_4 = 4'(SRC_Y);

  state_e                state_q, state_d;
  logic [7:0]            remaining_q, remaining_d;
  logic                  o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0] o_dat_q, o_dat_d;
  logic                  last_q, last_d;
  logic [15:0]           pkt_count_q, pkt_count_d;
  logic                  or_free_s;
  logic                  cmd_ready_s;
  logic                  pl_ready_s;
  logic                  cmd_fire_s;
  logic                  pl_fire_s;

  // Input-side handshakes: only one channel is open at a time, and only when the OR can take a flit.
  always_comb begin
    or_free_s = !o_valid_q || bus.o_ready;
    if (reset) begin
      cmd_ready_s = 1'b0;
      pl_ready_s  = 1'b0;
    end else if (state_q == IDLE) begin
      cmd_ready_s = or_free_s;
      pl_ready_s  = 1'b0;
    end else begin
      cmd_ready_s = 1'b0;
      pl_ready_s  = or_free_s;
    end
    cmd_fire_s = bus.cmd_valid && cmd_ready_s;
    pl_fire_s  = bus.pl_valid && pl_ready_s;
  end

  // Next-state for the packet FSM, the output register and the packet counter.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    o_valid_d   = o_valid_q;
    o_dat_d     = o_dat_q;
    last_d      = last_q;
    if (o_valid_q && bus.o_ready && last_q) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end else begin
      pkt_count_d = pkt_count_q;
    end
    if (cmd_fire_s) begin
      o_valid_d = 1'b1;
      o_dat_d   = {SRC_Y_4, SRC_X_4, bus.cmd_len, bus.cmd_dst_y, bus.cmd_dst_x};
      if (bus.cmd_len == 8'd0) begin
        // Header-only packet: stay in IDLE so the next command can follow immediately.
        last_d  = 1'b1;
        state_d = IDLE;
      end else begin
        last_d      = 1'b0;
        remaining_d = bus.cmd_len;
        state_d     = PAYLOAD;
      end
    end else if (pl_fire_s) begin
      o_valid_d   = 1'b1;
      o_dat_d     = bus.pl_dat;
      remaining_d = remaining_q - 8'd1;
      if (remaining_q == 8'd1) begin
        last_d  = 1'b1;
        state_d = IDLE;
      end else begin
        last_d  = 1'b0;
        state_d = PAYLOAD;
      end
    end else if (or_free_s) begin
      o_valid_d = 1'b0;
    end else begin
      o_valid_d = o_valid_q;
    end
  end

  // State registers; reset discards any partial packet.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= 8'd0;
      o_valid_q   <= 1'b0;
      o_dat_q     <= '0;
      last_q      <= 1'b0;
      pkt_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      o_valid_q   <= o_valid_d;
      o_dat_q     <= o_dat_d;
      last_q      <= last_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_s;
  assign bus.pl_ready  = pl_ready_s;
  assign bus.o_valid   = o_valid_q;
  assign bus.o_dat     = o_dat_q;
  assign pkt_count     = pkt_count_q;
endmodule

// File: tb/tb_fwnoc_ni_tx.sv
// Self-checking bench for fwnoc_ni_tx: directed and randomized packets checked
// every cycle against a queue-based packet model, plus literal header/count pins.
module tb_fwnoc_ni_tx;
  localparam int SRC_X = 1;
  localparam int SRC_Y = 1;

  typedef struct {
    logic [31:0] dat;
    bit          last;
  } flit_t;

  logic        clock;
  logic        reset;
  logic [15:0] pkt_count;
  fwnoc_ni_tx_if bus ();

  fwnoc_ni_tx #(.DATA_WIDTH(32), .SRC_X(SRC_X), .SRC_Y(SRC_Y)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .pkt_count (pkt_count)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          check_en = 1'b0;
  flit_t       exp_q[$];
  logic [31:0] seen[$];
  int          model_rem = 0;
  int          model_cnt = 0;
  flit_t       ent;
  int          rdy_mode = 0;
  int          pat_idx = 0;
  bit          pat[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] hdr(input int x, input int y, input int len);
    return 32'((SRC_Y % 16) * 32'h1000_0000 + (SRC_X % 16) * 32'h0100_0000
               + len * 32'h1_0000 + y * 32'h100 + x);
  endfunction

  // Output-ready generator: always ready, random, or a fixed toggle pattern.
  always @(posedge clock) begin
    #2;
    case (rdy_mode)
      1: bus.o_ready = 1'($urandom_range(0, 1));
      2: begin
        if (pat_idx < 8) begin
          bus.o_ready = pat[pat_idx];
          pat_idx++;
        end else begin
          bus.o_ready = 1'b1;
        end
      end
      default: bus.o_ready = 1'b1;
    endcase
  end

  // Per-cycle comparison against the packet model.
  always @(negedge clock) begin
    if (check_en) begin
      chk("o_valid", 32'(bus.o_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("o_dat", bus.o_dat, exp_q[0].dat);
      chk("pkt_count", 32'(pkt_count), 32'(model_cnt % 65536));
      chk("cmd_ready", 32'(bus.cmd_ready),
          32'(!reset && model_rem == 0 && (exp_q.size() == 0 || bus.o_ready)));
      chk("pl_ready", 32'(bus.pl_ready),
          32'(!reset && model_rem != 0 && (exp_q.size() == 0 || bus.o_ready)));
      if (bus.o_valid && !bus.o_ready) chk("pl_ready_stall", 32'(bus.pl_ready), 32'd0);
      if (reset) begin
        exp_q.delete();
        model_rem = 0;
        model_cnt = 0;
      end else begin
        if (bus.o_valid && bus.o_ready && exp_q.size() != 0) begin
          ent = exp_q.pop_front();
          seen.push_back(bus.o_dat);
          if (ent.last) model_cnt++;
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          exp_q.push_back('{hdr(bus.cmd_dst_x, bus.cmd_dst_y, bus.cmd_len), bus.cmd_len == 8'd0});
          model_rem = bus.cmd_len;
        end
        if (bus.pl_valid && bus.pl_ready) begin
          exp_q.push_back('{bus.pl_dat, model_rem == 1});
          if (model_rem > 0) model_rem--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_o_dat", bus.o_dat, 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    seen.delete();
  endtask

  task automatic send_cmd(input int x, input int y, input int len, output int cycles);
    bit done = 1'b0;
    bus.cmd_dst_x = 8'(x);
    bus.cmd_dst_y = 8'(y);
    bus.cmd_len   = 8'(len);
    bus.cmd_valid = 1'b1;
    cycles = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clock);
      done = bus.cmd_ready;
      cycles++;
      tick();
    end
    bus.cmd_valid = 1'b0;
    if (!done) chk("cmd_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_pl(input logic [31:0] dat, input bit gaps);
    bit done = 1'b0;
    if (gaps) begin
      bus.pl_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    bus.pl_dat   = dat;
    bus.pl_valid = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clock);
      done = bus.pl_ready;
      tick();
    end
    bus.pl_valid = 1'b0;
    if (!done) chk("pl_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clock);
      #1;
      done = (exp_q.size() == 0) && (model_rem == 0);
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
    tick();
  endtask

  initial begin
    int cyc;
    int len;
    logic [31:0] words[5];
    clock = 1'b0;
    reset = 1'b1;
    bus.cmd_dst_x = 8'd0; bus.cmd_dst_y = 8'd0; bus.cmd_len = 8'd0; bus.cmd_valid = 1'b0;
    bus.pl_dat = 32'd0; bus.pl_valid = 1'b0; bus.o_ready = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_en = 1'b1;
    chk("init_o_valid", 32'(bus.o_valid), 32'd0);
    chk("init_pkt_count", 32'(pkt_count), 32'd0);

    // Basic packet: header then two payload words.
    do_reset();
    send_cmd(1, 0, 2, cyc);
    send_pl(32'h0000_00A1, 1'b0);
    send_pl(32'h0000_00A2, 1'b0);
    wait_idle();
    chk("t1_len", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      chk("t1_hdr", seen[0], 32'h1102_0001);
      chk("t1_w0", seen[1], 32'h0000_00A1);
      chk("t1_w1", seen[2], 32'h0000_00A2);
    end
    chk("t1_count", 32'(pkt_count), 32'd1);

    // Three back-to-back zero-length packets.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_cmd(0, 1, 0, cyc);
      chk("t2_cmd_wait", 32'(cyc), 32'd1);
    end
    wait_idle();
    chk("t2_len", 32'(seen.size()), 32'd3);
    foreach (seen[i]) chk("t2_hdr", seen[i], 32'h1100_0100);
    chk("t2_count", 32'(pkt_count), 32'd3);

    // Stalled output with a fixed ready pattern.
    do_reset();
    pat_idx = 0;
    rdy_mode = 2;
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    send_cmd(7, 3, 4, cyc);
    for (int i = 0; i < 4; i++) send_pl(words[i], 1'b0);
    wait_idle();
    rdy_mode = 0;
    chk("t3_len", 32'(seen.size()), 32'd5);
    if (seen.size() == 5) begin
      chk("t3_hdr", seen[0], 32'h1104_0307);
      for (int i = 0; i < 4; i++) chk("t3_word", seen[i+1], words[i]);
    end

    // Maximum-length packet at full rate.
    do_reset();
    send_cmd(2, 2, 255, cyc);
    for (int i = 0; i < 255; i++) send_pl(32'(i * 3 + 5), 1'b0);
    wait_idle();
    chk("t4_len", 32'(seen.size()), 32'd256);
    if (seen.size() == 256) begin
      chk("t4_hdr", seen[0], 32'h11FF_0202);
      chk("t4_tail", seen[255], 32'd767);
    end
    chk("t4_count", 32'(pkt_count), 32'd1);

    // Reset in the middle of a packet, then a fresh short packet.
    do_reset();
    send_cmd(4, 4, 5, cyc);
    send_pl(32'h1111_1111, 1'b0);
    send_pl(32'h2222_2222, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("t5_o_valid", 32'(bus.o_valid), 32'd0);
    chk("t5_count", 32'(pkt_count), 32'd0);
    tick();
    seen.delete();
    send_cmd(5, 6, 1, cyc);
    send_pl(32'hCAFE_F00D, 1'b0);
    wait_idle();
    chk("t5_len", 32'(seen.size()), 32'd2);
    if (seen.size() == 2) begin
      chk("t5_hdr", seen[0], 32'h1101_0605);
      chk("t5_w0", seen[1], 32'hCAFE_F00D);
    end
    chk("t5_count2", 32'(pkt_count), 32'd1);

    // Randomized traffic with payload gaps and random output stalls.
    do_reset();
    rdy_mode = 1;
    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(0, 12);
      send_cmd($urandom_range(0, 255), $urandom_range(0, 255), len, cyc);
      for (int i = 0; i < len; i++) send_pl($urandom, 1'b1);
    end
    wait_idle();
    rdy_mode = 0;
    tick();
    chk("rand_count", 32'(pkt_count), 32'd30);

    // Counter wrap via 65535 zero-length packets plus one more.
    do_reset();
    bus.cmd_dst_x = 8'd9; bus.cmd_dst_y = 8'd9; bus.cmd_len = 8'd0; bus.cmd_valid = 1'b1;
    repeat (65535) tick();
    bus.cmd_valid = 1'b0;
    wait_idle();
    chk("wrap_full", 32'(pkt_count), 32'h0000_FFFF);
    send_cmd(9, 9, 0, cyc);
    wait_idle();
    chk("wrap_zero", 32'(pkt_count), 32'd0);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
